gsr_pur_assign_gen: RTL and testbench

Generates the two active-low global reset nets, GSR_sig (global set/reset) and PUR_sig (power-up reset), that primitive models such as the DDR DLL consume. PUR_sig is held asserted for a fixed number of cycles after reset. GSR_sig can additionally be asserted by a user request with a guaranteed minimum pulse width. It sits at the top of the design, and its outputs fan out to every block that derives `SRN = GSR_sig & PUR_sig`.

---
 rtl/gsr_pur_pkg.sv | 16 +
 rtl/gsr_pur_sync.sv | 29 ++
 rtl/gsr_pur_assign_gen.sv | 125 ++++++++++++
 tb/tb_gsr_pur_assign_gen.sv | 128 ++++++++++++
 4 files changed

// File: rtl/gsr_pur_pkg.sv
// rtl/gsr_pur_pkg.sv - shared types and default constants for the global reset generator
// Purpose: GSR FSM state encoding and default timing constants for gsr_pur_assign_gen.
// Ports: none (package).
package gsr_pur_pkg;

    localparam int PUR_CYC_DEF     = 16;
    localparam int GSR_MIN_CYC_DEF = 4;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        HOLD   = 2'd2
    } gsr_state_t;

endpackage

// File: rtl/gsr_pur_sync.sv
// rtl/gsr_pur_sync.sv - multi-flop synchronizer for an active-low asynchronous request
// Purpose: brings an asynchronous active-low input into the clkin_out domain.
// Ports:
//   clkin_out  in   clock
//   RST_int    in   synchronous active-high reset; every stage resets to 1 (inactive)
//   d          in   asynchronous input
//   q          out  synchronized output, STAGES edges behind d
module gsr_pur_sync #(
    parameter int STAGES = 2
) (
    input  logic clkin_out,
    input  logic RST_int,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_ff;

    always_ff @(posedge clkin_out) begin
        if (RST_int) begin
            sync_ff <= '1;
        end else begin
            sync_ff <= {sync_ff[STAGES-2:0], d};
        end
    end

    assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/gsr_pur_assign_gen.sv
// rtl/gsr_pur_assign_gen.sv - generator of the active-low GSR_sig and PUR_sig global reset nets
// Purpose: holds PUR_sig low for PUR_CYC cycles after RST release; GSR_sig follows PUR_sig
//   one edge later and, with GSR_PUR_REQ_EN defined, can also be pulsed low by GSRN_REQ
//   for at least GSR_MIN_CYC cycles. Without GSR_PUR_REQ_EN, GSRN_REQ is ignored.
// Ports:
//   CLK       in   single clock
//   RST       in   synchronous active-high reset
//   GSRN_REQ  in   asynchronous active-low GSR request
//   GSR_sig   out  active-low global set/reset, registered
//   PUR_sig   out  active-low power-up reset, registered
module gsr_pur_assign_gen
    import gsr_pur_pkg::*;
#(
    parameter int PUR_CYC     = PUR_CYC_DEF,
    parameter int GSR_MIN_CYC = GSR_MIN_CYC_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic GSRN_REQ,
    output logic GSR_sig,
    output logic PUR_sig
);

    localparam int PUR_W = $clog2(PUR_CYC + 1);
    localparam logic [PUR_W-1:0] PUR_MAX = PUR_W'(PUR_CYC);

    logic [PUR_W-1:0] pur_cnt;
    logic [PUR_W-1:0] pur_cnt_nxt;

    // Saturating power-up counter; PUR_sig releases on the edge the count reaches PUR_CYC.
    always_comb begin
        pur_cnt_nxt = pur_cnt;
        if (pur_cnt < PUR_MAX) begin
            pur_cnt_nxt = pur_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pur_cnt <= '0;
            PUR_sig <= 1'b0;
        end else begin
            pur_cnt <= pur_cnt_nxt;
            PUR_sig <= (pur_cnt_nxt == PUR_MAX);
        end
    end

`ifdef GSR_PUR_REQ_EN

    // A width of at least one bit keeps GSR_MIN_CYC=1 legal.
    localparam int GSR_W = (GSR_MIN_CYC > 1) ? $clog2(GSR_MIN_CYC) : 1;
    localparam logic [GSR_W-1:0] GSR_LAST = GSR_W'(GSR_MIN_CYC - 1);

    logic             req_s;
    gsr_state_t       state;
    gsr_state_t       state_nxt;
    logic [GSR_W-1:0] gsr_cnt;
    logic [GSR_W-1:0] gsr_cnt_nxt;

    gsr_pur_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clkin_out (CLK),
        .RST_int   (RST),
        .d         (GSRN_REQ),
        .q         (req_s)
    );

    // The counter holds at GSR_LAST on the exit edge so it never wraps.
    always_comb begin
        state_nxt   = state;
        gsr_cnt_nxt = gsr_cnt;
        case (state)
            IDLE: begin
                if (!req_s) begin
                    state_nxt   = ASSERT;
                    gsr_cnt_nxt = '0;
                end
            end
            ASSERT: begin
                if (gsr_cnt == GSR_LAST) begin
                    state_nxt = req_s ? IDLE : HOLD;
                end else begin
                    gsr_cnt_nxt = gsr_cnt + 1'b1;
                end
            end
            HOLD: begin
                if (req_s) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The FSM runs during PUR too; the PUR_sig term masks any request at the output.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            gsr_cnt <= '0;
            GSR_sig <= 1'b0;
        end else begin
            state   <= state_nxt;
            gsr_cnt <= gsr_cnt_nxt;
            GSR_sig <= (state_nxt == IDLE) && PUR_sig;
        end
    end

`else

    logic unused_gsrn_req;
    assign unused_gsrn_req = GSRN_REQ;

    always_ff @(posedge CLK) begin
        if (RST) begin
            GSR_sig <= 1'b0;
        end else begin
            GSR_sig <= PUR_sig;
        end
    end

`endif

endmodule

// File: tb/tb_gsr_pur_assign_gen.sv
// tb/tb_gsr_pur_assign_gen.sv - self-checking bench for gsr_pur_assign_gen (default parameters)
module tb_gsr_pur_assign_gen;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic GSRN_REQ = 1'b1;
    logic GSR_sig;
    logic PUR_sig;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic rst;
        logic req;
        logic exp_gsr;
        logic exp_pur;
    } vec_t;

    vec_t tbl [0:21];

    gsr_pur_assign_gen dut (
        .CLK      (CLK),
        .RST      (RST),
        .GSRN_REQ (GSRN_REQ),
        .GSR_sig  (GSR_sig),
        .PUR_sig  (PUR_sig)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Drive on the falling edge, take one rising edge, sample 1 time unit later.
    task automatic vec(input logic r, input logic q, input logic eg, input logic ep, input string name);
        @(negedge CLK);
        RST = r;
        GSRN_REQ = q;
        @(posedge CLK);
        #1;
        chk({name, "_gsr"}, GSR_sig, eg);
        chk({name, "_pur"}, PUR_sig, ep);
    endtask

    // Release edges 1..17 after a reset; optional request low on edges 1..3 (PUR window).
    task automatic pur_release(input bit req_in_window, input string name);
        for (int i = 1; i <= 17; i++) begin
            vec(1'b0, (req_in_window && i <= 3) ? 1'b0 : 1'b1,
                (i >= 17), (i >= 16), name);
        end
    endtask

`ifdef GSR_PUR_REQ_EN
    // From idle with PUR done: request low for low_len edges starting at edge j=0.
    task automatic req_pulse(input int low_len, input string name);
        int exp_low;
        exp_low = (low_len > 4) ? low_len : 4;
        for (int j = 0; j <= exp_low + 3; j++) begin
            vec(1'b0, (j < low_len) ? 1'b0 : 1'b1,
                !(j >= 2 && j < 2 + exp_low), 1'b1, name);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 22; i++) begin
            tbl[i].req = 1'b1;
            if (i < 3) begin
                tbl[i].rst = 1'b1; tbl[i].exp_gsr = 1'b0; tbl[i].exp_pur = 1'b0;
            end else begin
                tbl[i].rst = 1'b0;
                tbl[i].exp_pur = (i - 2 >= 16);
                tbl[i].exp_gsr = (i - 2 >= 17);
            end
        end

        for (int i = 0; i < 22; i++) begin
            vec(tbl[i].rst, tbl[i].req, tbl[i].exp_gsr, tbl[i].exp_pur, $sformatf("tbl%0d", i));
        end

        // Request during the PUR window yields no extra pulse.
        vec(1'b1, 1'b1, 1'b0, 1'b0, "rst_win");
        pur_release(1'b1, "pur_window");
        for (int i = 0; i < 6; i++) vec(1'b0, 1'b1, 1'b1, 1'b1, "after_window");

`ifdef GSR_PUR_REQ_EN
        req_pulse(1, "req1");
        req_pulse(4, "req4");
        req_pulse(5, "req5");
        req_pulse(10, "req10");

        // RST while the FSM is in ASSERT.
        vec(1'b0, 1'b0, 1'b1, 1'b1, "asrt_k0");
        vec(1'b0, 1'b1, 1'b1, 1'b1, "asrt_k1");
        vec(1'b0, 1'b1, 1'b0, 1'b1, "asrt_k2");
        vec(1'b0, 1'b1, 1'b0, 1'b1, "asrt_k3");
        vec(1'b1, 1'b1, 1'b0, 1'b0, "asrt_rst");
        pur_release(1'b0, "asrt_restart");
        for (int i = 0; i < 4; i++) vec(1'b0, 1'b1, 1'b1, 1'b1, "asrt_idle");
`else
        // Request ignored: GSR_sig is PUR_sig one edge late.
        begin
            logic q;
            logic prev_pur;
            vec(1'b1, 1'b0, 1'b0, 1'b0, "rnd_rst");
            prev_pur = 1'b0;
            for (int i = 1; i <= 30; i++) begin
                q = 1'($urandom_range(0, 1));
                vec(1'b0, q, prev_pur, (i >= 16), $sformatf("rnd%0d", i));
                prev_pur = (i >= 16);
            end
            for (int i = 0; i < 8; i++) vec(1'b0, 1'b0, 1'b1, 1'b1, "req_low_ignored");
            vec(1'b1, 1'b0, 1'b0, 1'b0, "mid_rst");
            pur_release(1'b0, "mid_restart");
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
